rvv_backend_mul_unit_seqmul: RTL and testbench
==============================================

# rvv_backend_mul_unit_seqmul

Multi-cycle signed/unsigned integer multiplier for one element of SEW 8/16/32. It is built around the existing 8×8 multiplier `rvv_backend_mul_unit_mul8`. The block sequences byte-pair operands into that multiplier one pair per cycle and accumulates the shifted 16-bit partial products into a full 2×SEW-bit result. It sits in the area-reduced MUL path between the uop dispatch register and the result writeback mux, with valid/ready handshakes on both sides.

## Interface
- `TAG_W`, default 8: width of the opaque uop tag carried alongside the operation.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept a request.
- `in_sew`  in  2  element width: 00=SEW8, 01=SEW16, 10=SEW32, 11=reserved (treated as SEW8).
- `in_src0`, `in_src1`  in  32  operands, right-aligned; bits above SEW ignored.
- `in_src0_is_signed`, `in_src1_is_signed`  in  1 each  per-operand signedness.
- `in_tag`  in  `TAG_W`  tag returned with the result.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  64  product in bits [2·SEW-1:0]; bits above are zero.
- `out_tag`  out  `TAG_W`  tag of the result.

## Operation
- Three-state FSM: IDLE, CALC, DONE.
- Transitions:
  - IDLE→CALC on `in_valid && in_ready`.
  - CALC→DONE after N compute cycles.
  - DONE→IDLE on `out_valid && out_ready && !in_valid`.
  - DONE→CALC on output handshake coinciding with new input handshake.
- N depends on SEW, with NB = SEW/8:
  - SEW8: N=1.
  - SEW16: N=4.
  - SEW32: N=16.
- Step counter k runs 0..N-1. Byte indices are i = k / NB and j = k mod NB.
  - The mul8 sees src0 byte i and src1 byte j.
  - `in0_is_signed` = src0 signed && i==NB-1; `in1_is_signed` likewise with j.
- Each 16-bit partial product is extended to 64 bits:
  - sign-extended if either byte signed flag for that pair is set;
  - zero-extended otherwise.
  - It is then shifted left 8·(i+j) and added to a 64-bit accumulator, modulo 2^64.
- In DONE, `out_data` = accumulator masked to 2·SEW bits.
- Operands, SEW, signedness and tag are latched on acceptance. Input pins are ignored thereafter.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready).
- On acceptance the accumulator clears. Accumulation is on the registered operands.
- `rst_n` low at any time, including mid-CALC or DONE:
  - state→IDLE; counter, accumulator and latched fields→0;
  - the in-flight operation is discarded, with no output.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_tag`=0, `in_ready`=1 (IDLE).
- Request accepted at edge E0. Compute cycles occupy the N cycles after E0.
- `out_valid` rises after edge E0+N and is visible in cycle N+1 relative to acceptance:
  - latency 2 for SEW8;
  - latency 5 for SEW16;
  - latency 17 for SEW32.
- Once high, `out_valid`, `out_data` and `out_tag` hold stable until `out_ready`.
- Back-to-back operation: output handshake and new acceptance in the same cycle. The next CALC starts the following cycle.
- Peak throughput is one result per N+1 cycles.
- `in_ready` is combinational from `out_ready` in DONE only. There is no other input-to-output combinational path.

## Structure
- SEW encoding constants go in the shared RVV backend package. Only that package is used; nothing is redefined locally.
  - `SEW8`=2'b00, `SEW16`=2'b01, `SEW32`=2'b10.
  - FSM state enum type `seqmul_state_e`.
- One sub-module instance: `rvv_backend_mul_unit_mul8`, unmodified, purely combinational. Operands are registered; only the accumulator adder is in the feedback loop.
- Byte select, extend/shift and accumulate logic stay in this block.

## Test plan
- SEW8 unsigned 0xFF×0xFF:
  - `out_data`=0x0000_0000_0000_FE01;
  - `out_valid` 2 cycles after accept;
  - tag echoed.
- SEW8 both signed 0x80×0x7F → 0x0000_0000_0000_C080 (−16256).
- SEW16 src0 signed 0xFFFF, src1 unsigned 0xFFFF → 0x0000_0000_FFFF_0001; latency 5.
- SEW32 both signed 0x8000_0000×0x8000_0000 → 0x4000_0000_0000_0000; latency 17.
- SEW32 unsigned 0xFFFF_FFFF×0xFFFF_FFFF → 0xFFFF_FFFE_0000_0001.
- Hold `out_ready` low 5 cycles:
  - `out_data` stable and `in_ready`=0 throughout;
  - then assert `out_ready` with `in_valid`: new op accepted same cycle.
- Assert `rst_n` low mid-CALC of a SEW32 op:
  - all outputs return to reset values immediately;
  - no `out_valid` for the aborted op;
  - a following SEW8 op completes normally.

Source files
------------

// File: rtl/rvv_backend_mul_unit_seqmul_pkg.sv
// Shared constants, FSM state type and SEW helpers for the sequential
// byte-serial element multiplier.
package rvv_backend_mul_unit_seqmul_pkg;

    localparam logic [1:0] SEW8  = 2'b00;
    localparam logic [1:0] SEW16 = 2'b01;
    localparam logic [1:0] SEW32 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } seqmul_state_e;

    // The reserved encoding behaves as SEW8, so it is folded away on latch.
    function automatic logic [1:0] sew_norm(input logic [1:0] sew);
        return ((sew == SEW16) || (sew == SEW32)) ? sew : SEW8;
    endfunction

    function automatic logic [3:0] sew_last_step(input logic [1:0] sew);
        logic [3:0] last;
        case (sew)
            SEW16:   last = 4'd3;
            SEW32:   last = 4'd15;
            default: last = 4'd0;
        endcase
        return last;
    endfunction

    function automatic logic [63:0] sew_result_mask(input logic [1:0] sew);
        logic [63:0] mask;
        case (sew)
            SEW16:   mask = 64'h0000_0000_FFFF_FFFF;
            SEW32:   mask = 64'hFFFF_FFFF_FFFF_FFFF;
            default: mask = 64'h0000_0000_0000_FFFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/rvv_backend_mul_unit_mul8.sv
// Combinational 8x8 multiplier; each operand is independently signed or
// unsigned, and the 16-bit result is exact for every combination.
module rvv_backend_mul_unit_mul8 (
    input  logic [7:0]  in0,
    input  logic [7:0]  in1,
    input  logic        in0_is_signed,
    input  logic        in1_is_signed,
    output logic [15:0] res
);

    logic [15:0] in0_ext;
    logic [15:0] in1_ext;

    // Two's complement product modulo 2^16 equals the exact product here.
    assign in0_ext = {{8{in0_is_signed & in0[7]}}, in0};
    assign in1_ext = {{8{in1_is_signed & in1[7]}}, in1};
    assign res     = in0_ext * in1_ext;

endmodule

// File: rtl/rvv_backend_mul_unit_seqmul.sv
// Multi-cycle SEW8/16/32 element multiplier: one byte pair per cycle through
// a shared 8x8 multiplier, shifted partial products summed into 64 bits.
//
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds its payload until then, the consumer may drop ready freely.
module rvv_backend_mul_unit_seqmul
    import rvv_backend_mul_unit_seqmul_pkg::*;
#(
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sew,
    input  logic [31:0]      in_src0,
    input  logic [31:0]      in_src1,
    input  logic             in_src0_is_signed,
    input  logic             in_src1_is_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [TAG_W-1:0] out_tag
);

    seqmul_state_e    state_q;
    logic [3:0]       cnt_q;
    logic [63:0]      acc_q;
    logic [63:0]      acc_d;
    logic [31:0]      src0_q;
    logic [31:0]      src1_q;
    logic [1:0]       sew_q;
    logic             src0_signed_q;
    logic             src1_signed_q;
    logic [TAG_W-1:0] tag_q;

    logic             accept;
    logic [1:0]       idx_i;
    logic [1:0]       idx_j;
    logic [1:0]       idx_top;
    logic [2:0]       byte_pos;
    logic [5:0]       shamt;
    logic [7:0]       byte0;
    logic [7:0]       byte1;
    logic             byte0_signed;
    logic             byte1_signed;
    logic [15:0]      pp;
    logic [63:0]      pp_ext;

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = (state_q == ST_DONE) ? (acc_q & sew_result_mask(sew_q)) : 64'h0;
    assign out_tag   = (state_q == ST_DONE) ? tag_q : '0;

    // k = {i, j} with j the low log2(NB) bits of the step counter.
    always_comb begin
        idx_i   = 2'd0;
        idx_j   = 2'd0;
        idx_top = 2'd0;
        case (sew_q)
            SEW16: begin
                idx_i   = {1'b0, cnt_q[1]};
                idx_j   = {1'b0, cnt_q[0]};
                idx_top = 2'd1;
            end
            SEW32: begin
                idx_i   = cnt_q[3:2];
                idx_j   = cnt_q[1:0];
                idx_top = 2'd3;
            end
            default: ;
        endcase
    end

    assign byte0        = src0_q[{idx_i, 3'b000} +: 8];
    assign byte1        = src1_q[{idx_j, 3'b000} +: 8];
    assign byte0_signed = src0_signed_q && (idx_i == idx_top);
    assign byte1_signed = src1_signed_q && (idx_j == idx_top);

    rvv_backend_mul_unit_mul8 u_mul8 (
        .in0           (byte0),
        .in1           (byte1),
        .in0_is_signed (byte0_signed),
        .in1_is_signed (byte1_signed),
        .res           (pp)
    );

    // A partial product can only be negative when one of its bytes is a
    // signed top byte; otherwise it is a plain unsigned value.
    assign pp_ext   = (byte0_signed || byte1_signed) ? {{48{pp[15]}}, pp} : {48'h0, pp};
    assign byte_pos = {1'b0, idx_i} + {1'b0, idx_j};
    assign shamt    = {byte_pos, 3'b000};
    assign acc_d    = acc_q + (pp_ext << shamt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 4'd0;
            acc_q         <= 64'h0;
            src0_q        <= 32'h0;
            src1_q        <= 32'h0;
            sew_q         <= SEW8;
            src0_signed_q <= 1'b0;
            src1_signed_q <= 1'b0;
            tag_q         <= '0;
        end else if (accept) begin
            state_q       <= ST_CALC;
            cnt_q         <= 4'd0;
            acc_q         <= 64'h0;
            src0_q        <= in_src0;
            src1_q        <= in_src1;
            sew_q         <= sew_norm(in_sew);
            src0_signed_q <= in_src0_is_signed;
            src1_signed_q <= in_src1_is_signed;
            tag_q         <= in_tag;
        end else begin
            case (state_q)
                ST_CALC: begin
                    acc_q <= acc_d;
                    if (cnt_q == sew_last_step(sew_q)) begin
                        state_q <= ST_DONE;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rvv_backend_mul_unit_seqmul.sv
// Randomized and directed bench for the sequential element multiplier,
// checked against a plain-arithmetic product model.
module tb_rvv_backend_mul_unit_seqmul;
    import rvv_backend_mul_unit_seqmul_pkg::*;

    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_sew;
    logic [31:0]      in_src0;
    logic [31:0]      in_src1;
    logic             in_src0_is_signed;
    logic             in_src1_is_signed;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic [TAG_W-1:0] out_tag;

    logic [71:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    rvv_backend_mul_unit_seqmul #(.TAG_W(TAG_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_sew            (in_sew),
        .in_src0           (in_src0),
        .in_src1           (in_src1),
        .in_src0_is_signed (in_src0_is_signed),
        .in_src1_is_signed (in_src1_is_signed),
        .in_tag            (in_tag),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_tag           (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string what, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", what, got, exp, $time);
        end
    endtask

    function automatic int steps(input logic [1:0] sew);
        return (sew == SEW16) ? 4 : (sew == SEW32) ? 16 : 1;
    endfunction

    // Operand values as integers of the element width, product mod 2^64,
    // then truncated to 2*SEW bits.
    function automatic logic [63:0] ref_mul(input logic [1:0] sew, input logic [31:0] a,
                                           input logic [31:0] b, input logic sa, input logic sb);
        int          w;
        logic [63:0] lo, ea, eb, m;
        w  = (sew == SEW16) ? 16 : (sew == SEW32) ? 32 : 8;
        lo = (64'd1 << w) - 64'd1;
        ea = {32'h0, a} & lo;
        eb = {32'h0, b} & lo;
        if (sa && a[w-1]) ea = ea | ~lo;
        if (sb && b[w-1]) eb = eb | ~lo;
        m  = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        return (ea * eb) & m;
    endfunction

    // Called one step after a rising edge; leaves the bench at the same phase.
    task automatic start_op(input logic [1:0] sew, input logic [31:0] a, input logic [31:0] b,
                            input logic sa, input logic sb, input logic [7:0] tag, input bit rel);
        in_valid          = 1'b1;
        in_sew            = sew;
        in_src0           = a;
        in_src1           = b;
        in_src0_is_signed = sa;
        in_src1_is_signed = sb;
        in_tag            = tag;
        out_ready         = rel;
        #1;
        check("in_ready_at_req", 64'(in_ready), 64'd1);
        exp_q.push_back({tag, ref_mul(sew, a, b, sa, sb)});
        @(posedge clk);
        #1;
        in_valid          = 1'b0;
        out_ready         = 1'b0;
        in_sew            = 2'($urandom_range(0, 3));
        in_src0           = $urandom;
        in_src1           = $urandom;
        in_src0_is_signed = 1'($urandom_range(0, 1));
        in_src1_is_signed = 1'($urandom_range(0, 1));
        in_tag            = 8'($urandom);
    endtask

    task automatic wait_result(input int n, output logic [63:0] data);
        int          lat;
        logic [71:0] e;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(n + 1));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 72'h0;
        check("data", out_data, e[63:0]);
        check("tag", 64'(out_tag), 64'(e[71:64]));
        data = out_data;
    endtask

    task automatic release_only();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_after_release", 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] d;
        logic [63:0] held;
        logic [1:0]  sew;
        bit          rel_pending;
        int          seen;

        rst_n             = 1'b0;
        in_valid          = 1'b0;
        in_sew            = SEW8;
        in_src0           = 32'h0;
        in_src1           = 32'h0;
        in_src0_is_signed = 1'b0;
        in_src1_is_signed = 1'b0;
        in_tag            = '0;
        out_ready         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        start_op(SEW8, 32'h0000_00FF, 32'h0000_00FF, 1'b0, 1'b0, 8'hA5, 1'b0);
        wait_result(1, d);
        check("sew8_uu_const", d, 64'h0000_0000_0000_FE01);
        release_only();

        start_op(SEW8, 32'hABCD_EF80, 32'h1234_567F, 1'b1, 1'b1, 8'h3C, 1'b0);
        wait_result(1, d);
        check("sew8_ss_const", d, 64'h0000_0000_0000_C080);
        release_only();

        start_op(SEW16, 32'h1234_FFFF, 32'h0000_FFFF, 1'b1, 1'b0, 8'h16, 1'b0);
        wait_result(4, d);
        check("sew16_su_const", d, 64'h0000_0000_FFFF_0001);
        release_only();

        start_op(SEW32, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 8'h32, 1'b0);
        wait_result(16, d);
        check("sew32_ss_const", d, 64'h4000_0000_0000_0000);
        release_only();

        start_op(SEW32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 8'h77, 1'b0);
        wait_result(16, d);
        check("sew32_uu_const", d, 64'hFFFF_FFFE_0000_0001);
        release_only();

        // Output held under backpressure, then released together with a new request.
        start_op(SEW16, $urandom, $urandom, 1'b1, 1'b1, 8'h5A, 1'b0);
        wait_result(4, held);
        repeat (5) begin
            check("hold_data", out_data, held);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        start_op(SEW8, 32'h0000_0081, 32'h0000_0003, 1'b1, 1'b0, 8'hB2, 1'b1);
        check("b2b_calc_no_valid", 64'(out_valid), 64'd0);
        check("b2b_calc_not_ready", 64'(in_ready), 64'd0);
        wait_result(1, d);
        release_only();

        // Reset in the middle of a SEW32 computation discards it.
        start_op(SEW32, $urandom, $urandom, 1'b1, 1'b0, 8'hEE, 1'b0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_data", out_data, 64'd0);
        check("abort_out_tag", 64'(out_tag), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("abort_no_result", 64'(seen), 64'd0);
        start_op(SEW8, 32'h0000_00FE, 32'h0000_0007, 1'b1, 1'b1, 8'h09, 1'b0);
        wait_result(1, d);
        release_only();

        rel_pending = 1'b0;
        for (int i = 0; i < 40; i++) begin
            sew = 2'($urandom_range(0, 3));
            if (rel_pending && ($urandom_range(0, 1) == 1)) begin
                start_op(sew, $urandom, $urandom, 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
            end else begin
                if (rel_pending) release_only();
                start_op(sew, $urandom, $urandom, 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
            end
            wait_result(steps(sew), d);
            rel_pending = 1'b1;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        if (rel_pending) release_only();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
